// File: rtl/pwm_breath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_breath_sequencer
// Description : 8-LED PWM driver whose duty ramps up, holds, ramps down and
//               holds again while enabled ("breathing"). Define ANTIPHASE_EN
//               to drive odd LEDs with the inverted duty.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_breath_sequencer #(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int PWM_FREQ     = 1_000,
    parameter int DUTY_STEP    = 4,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_PERIODS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [7:0] leds,
    output logic [7:0] duty,
    output logic [2:0] state,
    output logic       frame_end
);

    localparam int PRESCALE = CLK_FREQ / (PWM_FREQ * 256);
    localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int MAX_P    = (STEP_PERIODS > HOLD_PERIODS) ? STEP_PERIODS : HOLD_PERIODS;
    localparam int FC_W     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [FC_W-1:0] STEP_LAST = FC_W'(STEP_PERIODS - 1);
    localparam logic [FC_W-1:0] HOLD_LAST = FC_W'(HOLD_PERIODS - 1);
    localparam logic [8:0]      STEP9     = 9'(DUTY_STEP);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_HOLD_HI   = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_HOLD_LO   = 3'd4
    } state_t;

    logic [PS_W-1:0] presc_q;
    logic [7:0]      pwm_cnt_q;
    logic [7:0]      duty_q;
    logic [7:0]      duty_next_q;
    logic [FC_W-1:0] frame_cnt_q;
    state_t          state_q;
    logic [7:0]      leds_q;
    logic [7:0]      leds_d;

    logic       tick;
    logic       frame_end_w;
    logic [8:0] up_sum;
    logic [7:0] up_sat;
    logic [7:0] dn_sat;

    assign tick        = (presc_q == PS_LAST);
    assign frame_end_w = tick && (pwm_cnt_q == 8'hFF);

    // Saturating step arithmetic; the 9-bit sum catches overflow past 255.
    assign up_sum = {1'b0, duty_next_q} + STEP9;
    assign up_sat = up_sum[8] ? 8'hFF : up_sum[7:0];
    assign dn_sat = ({1'b0, duty_next_q} > STEP9) ? (duty_next_q - STEP9[7:0]) : 8'h00;

`ifdef ANTIPHASE_EN
    logic cmp_even;
    logic cmp_odd;
    assign cmp_even = (pwm_cnt_q < duty_q);
    assign cmp_odd  = (pwm_cnt_q < (8'hFF - duty_q));
    always_comb begin
        leds_d = '0;
        if (state_q != S_IDLE) begin
            leds_d = {cmp_odd, cmp_even, cmp_odd, cmp_even,
                      cmp_odd, cmp_even, cmp_odd, cmp_even};
        end
    end
`else
    always_comb begin
        leds_d = {8{pwm_cnt_q < duty_q}};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            leds_q    <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PS_W'(1);
            if (tick) begin
                pwm_cnt_q <= pwm_cnt_q + 8'd1;
            end
            // Duty only changes at the frame boundary so no pulse is ever cut short.
            if (frame_end_w) begin
                duty_q <= duty_next_q;
            end
            leds_q <= leds_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            duty_next_q <= '0;
            frame_cnt_q <= '0;
        end else if (frame_end_w) begin
            if ((state_q != S_IDLE) && !enable) begin
                state_q     <= S_IDLE;
                duty_next_q <= '0;
                frame_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        duty_next_q <= '0;
                        frame_cnt_q <= '0;
                        if (enable) begin
                            state_q <= S_RAMP_UP;
                        end
                    end
                    S_RAMP_UP: begin
                        if (frame_cnt_q == STEP_LAST) begin
                            frame_cnt_q <= '0;
                            duty_next_q <= up_sat;
                            if (up_sat == 8'hFF) begin
                                state_q <= S_HOLD_HI;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FC_W'(1);
                        end
                    end
                    S_HOLD_HI: begin
                        if (frame_cnt_q == HOLD_LAST) begin
                            frame_cnt_q <= '0;
                            state_q     <= S_RAMP_DOWN;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FC_W'(1);
                        end
                    end
                    S_RAMP_DOWN: begin
                        if (frame_cnt_q == STEP_LAST) begin
                            frame_cnt_q <= '0;
                            duty_next_q <= dn_sat;
                            if (dn_sat == 8'h00) begin
                                state_q <= S_HOLD_LO;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FC_W'(1);
                        end
                    end
                    S_HOLD_LO: begin
                        if (frame_cnt_q == HOLD_LAST) begin
                            frame_cnt_q <= '0;
                            state_q     <= S_RAMP_UP;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FC_W'(1);
                        end
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        duty_next_q <= '0;
                        frame_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign leds      = leds_q;
    assign duty      = duty_q;
    assign state     = state_q;
    assign frame_end = frame_end_w;

endmodule
`default_nettype wire

// File: tb/tb_pwm_breath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_breath_sequencer
// Description : Directed, table-driven bench for pwm_breath_sequencer with
//               256-clk frames, DUTY_STEP=64, STEP_PERIODS=1, HOLD_PERIODS=2.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_breath_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] leds;
    logic [7:0] duty;
    logic [2:0] state;
    logic       frame_end;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       en;
        logic       dark;
        logic [2:0] st;
        logic [7:0] dt;
    } vec_t;

    vec_t tbl[18];

    pwm_breath_sequencer #(
        .CLK_FREQ    (2560),
        .PWM_FREQ    (10),
        .DUTY_STEP   (64),
        .STEP_PERIODS(1),
        .HOLD_PERIODS(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .leds     (leds),
        .duty     (duty),
        .state    (state),
        .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive enable, wait for the next frame_end, then check state/duty just after it.
    task automatic run_vec(input logic en, input logic dark, input logic [2:0] st,
                           input logic [7:0] dt, input string tag);
        bit seen = 1'b0;
        bit lit  = 1'b0;
        enable = en;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (leds != 8'h00) lit = 1'b1;
            if (frame_end) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " frame_end seen"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " duty"}, 32'(duty), 32'(dt));
        if (dark) check({tag, " leds dark"}, 32'(lit), 32'd0);
    endtask

    task automatic count_frame(output int hi0, output int hi1, output int edges0, output int split);
        logic p = 1'b0;
        hi0 = 0; hi1 = 0; edges0 = 0; split = 0;
        for (int i = 0; i < 256; i++) begin
            if (leds[0]) hi0++;
            if (leds[1]) hi1++;
            if (i > 0 && leds[0] != p) edges0++;
            p = leds[0];
            if (leds != 8'h00 && leds != 8'hFF) split++;
            if (i < 255) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("reset outputs", 32'({leds, duty, state, frame_end}), 32'd0);
        end
        rst_n  = 1'b1;
        enable = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi0, hi1, edges0, split;
        rst_n  = 1'b0;
        enable = 1'b1;

        tbl[0]  = '{1'b0, 1'b1, 3'd0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 3'd0, 8'd0};
        tbl[2]  = '{1'b0, 1'b1, 3'd0, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 3'd1, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 3'd1, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 3'd1, 8'd64};
        tbl[6]  = '{1'b1, 1'b0, 3'd1, 8'd128};
        tbl[7]  = '{1'b1, 1'b0, 3'd2, 8'd192};
        tbl[8]  = '{1'b1, 1'b0, 3'd2, 8'd255};
        tbl[9]  = '{1'b1, 1'b0, 3'd3, 8'd255};
        tbl[10] = '{1'b1, 1'b0, 3'd3, 8'd255};
        tbl[11] = '{1'b1, 1'b0, 3'd3, 8'd191};
        tbl[12] = '{1'b1, 1'b0, 3'd3, 8'd127};
        tbl[13] = '{1'b1, 1'b0, 3'd4, 8'd63};
        tbl[14] = '{1'b1, 1'b0, 3'd4, 8'd0};
        tbl[15] = '{1'b1, 1'b0, 3'd1, 8'd0};
        tbl[16] = '{1'b1, 1'b0, 3'd1, 8'd0};
        tbl[17] = '{1'b1, 1'b0, 3'd1, 8'd64};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            run_vec(tbl[i].en, tbl[i].dark, tbl[i].st, tbl[i].dt, $sformatf("vec%0d", i));
        end

        // Frame with duty=64 just applied.
        count_frame(hi0, hi1, edges0, split);
        check("duty64 led0 high clks", 32'(hi0), 32'd64);
        check("duty64 led0 edges", 32'(edges0), 32'd2);
`ifdef ANTIPHASE_EN
        check("duty64 led1 high clks", 32'(hi1), 32'd191);
`else
        check("duty64 leds identical", 32'(split), 32'd0);
`endif
        run_vec(1'b1, 1'b0, 3'd1, 8'd128, "ramp2 128");
        run_vec(1'b1, 1'b0, 3'd2, 8'd192, "ramp2 192");
        run_vec(1'b1, 1'b0, 3'd2, 8'd255, "ramp2 255");
        count_frame(hi0, hi1, edges0, split);
        check("duty255 led0 high clks", 32'(hi0), 32'd255);
`ifdef ANTIPHASE_EN
        check("duty255 led1 high clks", 32'(hi1), 32'd0);
`else
        check("duty255 leds identical", 32'(split), 32'd0);
`endif
        run_vec(1'b1, 1'b0, 3'd3, 8'd255, "hold_hi exit");

        // Disable while duty=128 in RAMP_UP, then re-enable.
        do_reset();
        run_vec(1'b1, 1'b1, 3'd1, 8'd0,   "dis start");
        run_vec(1'b1, 1'b0, 3'd1, 8'd0,   "dis ramp0");
        run_vec(1'b1, 1'b0, 3'd1, 8'd64,  "dis ramp64");
        run_vec(1'b1, 1'b0, 3'd1, 8'd128, "dis ramp128");
        run_vec(1'b0, 1'b0, 3'd0, 8'd192, "dis to idle");
        run_vec(1'b0, 1'b0, 3'd0, 8'd0,   "dis duty0");
        run_vec(1'b1, 1'b1, 3'd1, 8'd0,   "reen start");
        run_vec(1'b1, 1'b0, 3'd1, 8'd0,   "reen ramp0");
        run_vec(1'b1, 1'b0, 3'd1, 8'd64,  "reen ramp64");

        // Asynchronous reset at pwm_cnt=100 with duty=192.
        do_reset();
        run_vec(1'b1, 1'b1, 3'd1, 8'd0,   "arst start");
        run_vec(1'b1, 1'b0, 3'd1, 8'd0,   "arst ramp0");
        run_vec(1'b1, 1'b0, 3'd1, 8'd64,  "arst ramp64");
        run_vec(1'b1, 1'b0, 3'd1, 8'd128, "arst ramp128");
        run_vec(1'b1, 1'b0, 3'd2, 8'd192, "arst duty192");
        repeat (100) @(posedge clk);
        #1;
        check("arst pre leds0 lit", 32'(leds[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst leds", 32'(leds), 32'd0);
        check("arst state", 32'(state), 32'd0);
        check("arst duty", 32'(duty), 32'd0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b0;
        run_vec(1'b0, 1'b1, 3'd0, 8'd0, "post arst idle");
        run_vec(1'b1, 1'b1, 3'd1, 8'd0, "post arst restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
